data_sram_like_bridge: RTL and testbench

Sits directly downstream of the CPU top's data-SRAM port (en / wen[3:0] / addr / wdata / rdata). Converts the single-cycle SRAM access into the team's handshaked sram-like bus (req/addr_ok/data_ok) so data memory latency can vary. Raises a stall that holds the MEM stage until the access completes, and returns load data registered.

---
 rtl/data_sram_like_bridge_pkg.sv | 16 +
 rtl/dsram_wen_decode.sv | 26 ++
 rtl/data_sram_like_bridge.sv | 151 +++++++++++++++
 tb/tb_data_sram_like_bridge.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_like_bridge_pkg.sv
// Shared encodings for the data-side SRAM-to-sram-like bus bridge and its wen decoder.
package data_sram_like_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/dsram_wen_decode.sv
// Maps SRAM byte write enables to an sram-like transfer size and the low two address bits.
module dsram_wen_decode
  import data_sram_like_bridge_pkg::*;
(
  input  logic [3:0] wen,
  output logic [1:0] size,
  output logic [1:0] addr_lo
);

  always_comb begin
    // NOTE: every output gets a value before the case so no path can infer a latch.
    size    = SIZE_WORD;
    addr_lo = 2'd0;
    case (wen)
      4'b0001: begin size = SIZE_BYTE; addr_lo = 2'd0; end
      4'b0010: begin size = SIZE_BYTE; addr_lo = 2'd1; end
      4'b0100: begin size = SIZE_BYTE; addr_lo = 2'd2; end
      4'b1000: begin size = SIZE_BYTE; addr_lo = 2'd3; end
      4'b0011: begin size = SIZE_HALF; addr_lo = 2'd0; end
      4'b1100: begin size = SIZE_HALF; addr_lo = 2'd2; end
      // Loads, full words and sparse strobe patterns all go out as aligned words.
      default: ;
    endcase
  end

endmodule

// File: rtl/data_sram_like_bridge.sv
// Converts the CPU's single-cycle data-SRAM port into a handshaked sram-like bus access.
// Define DSRAM_BRIDGE_POSTED_WRITE_EN to let stores complete to the CPU on address acceptance.
module data_sram_like_bridge
  import data_sram_like_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_en,
  input  logic [3:0]        cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_cancel,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  input  logic              addr_ok,
  input  logic [DATA_W-1:0] rdata,
  input  logic              data_ok
);

  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(3);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        dec_size;
  logic [1:0]        dec_addr_lo;
  logic              post_busy;

  dsram_wen_decode u_wen_decode (
    .wen     (cpu_wen),
    .size    (dec_size),
    .addr_lo (dec_addr_lo)
  );

`ifdef DSRAM_BRIDGE_POSTED_WRITE_EN
  localparam bit POSTED_EN = 1'b1;
  logic posted_q, posted_d;

  // A posted store is still owed a data_ok; new accesses wait in IDLE until it lands.
  always_comb begin
    posted_d = posted_q;
    if (data_ok) posted_d = 1'b0;
    if (state_q == S_REQ && addr_ok && wr_q) posted_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) posted_q <= 1'b0;
    else         posted_q <= posted_d;
  end

  assign post_busy = posted_q;
`else
  localparam bit POSTED_EN = 1'b0;
  assign post_busy = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_en && !cpu_cancel && !post_busy) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          wr_d    = |cpu_wen;
          size_d  = dec_size;
          addr_d  = (cpu_addr & ~LANE_MASK) | ADDR_W'(dec_addr_lo);
          wdata_d = cpu_wdata;
          wstrb_d = cpu_wen;
        end
      end
      S_REQ: begin
        if (addr_ok) begin
          req_d = 1'b0;
          if (POSTED_EN && wr_q) state_d = S_DONE;
          else if (cpu_cancel)   state_d = S_DRAIN;
          else                   state_d = S_WAIT;
        end else if (cpu_cancel) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // A beat arriving together with cancel is simply dropped.
        if (cpu_cancel) begin
          state_d = data_ok ? S_IDLE : S_DRAIN;
        end else if (data_ok) begin
          state_d = S_DONE;
          if (!wr_q) rdata_d = rdata;
        end
      end
      S_DRAIN: if (data_ok) state_d = S_IDLE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    if (!resetn) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= 4'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

  assign cpu_stall = !cpu_cancel &&
                     ((state_q == S_IDLE && cpu_en) || state_q == S_REQ || state_q == S_WAIT);
  assign cpu_rdata = rdata_q;
  assign req       = req_q;
  assign wr        = wr_q;
  assign size      = size_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Directed bench for data_sram_like_bridge: transaction-level model plus hand-computed checkpoints.
module tb_data_sram_like_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_en = 1'b0;
  logic [3:0]  cpu_wen = 4'd0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_cancel = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        addr_ok = 1'b0;
  logic [31:0] rdata = '0;
  logic        data_ok = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  data_sram_like_bridge dut (
    .clk(clk), .resetn(resetn), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_cancel(cpu_cancel), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .addr_ok(addr_ok), .rdata(rdata), .data_ok(data_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- bus responder: configurable address / data latency ----------------
  int          aok_delay = 0;
  int          dok_delay = 0;
  logic [31:0] bus_rdata = '0;
  int          req_age = 0;
  bit          pend = 1'b0;
  int          dwait = 0;
  int          hs_count = 0;
  logic [31:0] hs_addr[$];

  always @(posedge clk) begin
    if (!resetn) begin
      pend = 1'b0;
      req_age = 0;
    end else begin
      if (data_ok) pend = 1'b0;
      if (req && addr_ok) begin
        hs_count++;
        hs_addr.push_back(addr);
        pend = 1'b1;
        dwait = dok_delay;
        req_age = 0;
      end else begin
        if (pend && dwait > 0) dwait--;
        if (req) req_age++;
        else     req_age = 0;
      end
    end
    #1;
    addr_ok = req && (req_age >= aok_delay);
    data_ok = pend && (dwait == 0);
    rdata   = bus_rdata;
  end

  // ---------------- transaction-level reference model ----------------
`ifdef DSRAM_BRIDGE_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  bit          m_ok = 1'b0;
  bit          m_busy, m_acked, m_drain, m_done, m_posted, m_block;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata, m_rdata;

  function automatic logic [1:0] exp_size(input logic [3:0] w);
    case (w)
      4'd1, 4'd2, 4'd4, 4'd8: return 2'd0;
      4'd3, 4'd12:            return 2'd1;
      default:                return 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] exp_lane(input logic [3:0] w);
    case (w)
      4'd2:        return 2'd1;
      4'd4, 4'd12: return 2'd2;
      4'd8:        return 2'd3;
      default:     return 2'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      m_ok = 1'b1;
      m_busy = 0; m_acked = 0; m_drain = 0; m_done = 0; m_posted = 0;
      m_rdata = '0;
    end else if (m_ok) begin
      m_block = m_posted;
      if (data_ok) m_posted = 1'b0;
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_drain) begin
        if (data_ok) m_drain = 1'b0;
      end else if (m_busy && !m_acked) begin
        if (addr_ok) begin
          m_acked = 1'b1;
          if (POSTED && m_wr) begin m_busy = 0; m_done = 1; m_posted = 1; end
          else if (cpu_cancel) begin m_busy = 0; m_drain = 1; end
        end else if (cpu_cancel) begin
          m_busy = 1'b0;
        end
      end else if (m_busy) begin
        if (cpu_cancel) begin
          m_busy = 1'b0;
          m_drain = !data_ok;
        end else if (data_ok) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          if (!m_wr) m_rdata = rdata;
        end
      end else if (cpu_en && !cpu_cancel && !m_block) begin
        m_busy  = 1'b1;
        m_acked = 1'b0;
        m_wr    = |cpu_wen;
        m_size  = exp_size(cpu_wen);
        m_addr  = {cpu_addr[31:2], exp_lane(cpu_wen)};
        m_wdata = cpu_wdata;
        m_wstrb = cpu_wen;
      end
    end
  end

  // Every-cycle comparison against the model.
  bit c_idle, c_stall, c_req;
  always @(negedge clk) begin
    if (m_ok && resetn) begin
      c_idle  = !m_busy && !m_drain && !m_done;
      c_stall = !cpu_cancel && (m_busy || (c_idle && cpu_en));
      c_req   = m_busy && !m_acked;
      check("model_stall", 32'(cpu_stall), 32'(c_stall));
      check("model_req", 32'(req), 32'(c_req));
      check("model_rdata", cpu_rdata, m_rdata);
      if (c_req) begin
        check("model_wr", 32'(wr), 32'(m_wr));
        check("model_size", 32'(size), 32'(m_size));
        check("model_addr", addr, m_addr);
        check("model_wstrb", 32'(wstrb), 32'(m_wstrb));
        if (m_wr) check("model_wdata", wdata, m_wdata);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    cpu_en = 1'b1;
    cpu_wen = w;
    cpu_addr = a;
    cpu_wdata = d;
  endtask

  task automatic wait_done(input int max, output int lat);
    lat = 0;
    forever begin
      #1;
      if (lat >= 1 && !cpu_stall) break;
      if (lat >= max) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_done: stall still %0b after %0d cycles, want 0", cpu_stall, lat);
        break;
      end
      step();
      lat++;
    end
  endtask

  task automatic store_and_check(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [1:0] es, input logic [31:0] ea);
    int lat;
    start(w, a, d);
    step();
    #1;
    check("st_req", 32'(req), 32'd1);
    check("st_wr", 32'(wr), 32'd1);
    check("st_size", 32'(size), 32'(es));
    check("st_addr", addr, ea);
    check("st_wstrb", 32'(wstrb), 32'(w));
    check("st_wdata", wdata, d);
    wait_done(30, lat);
    cpu_en = 1'b0;
    step();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2, hs0;

    // Reset state
    step(); step();
    #1;
    check("rst_req", 32'(req), 32'd0);
    check("rst_wr", 32'(wr), 32'd0);
    check("rst_size", 32'(size), 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_wstrb", 32'(wstrb), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    resetn = 1'b1;
    step();

    // Minimum-latency load
    aok_delay = 0; dok_delay = 0; bus_rdata = 32'hDEAD_BEEF;
    start(4'd0, 32'h1000_0004, 32'h0);
    #1;
    check("ld_c0_stall", 32'(cpu_stall), 32'd1);
    check("ld_c0_req", 32'(req), 32'd0);
    step(); #1;
    check("ld_c1_req", 32'(req), 32'd1);
    check("ld_c1_size", 32'(size), 32'd2);
    check("ld_c1_wr", 32'(wr), 32'd0);
    check("ld_c1_addr", addr, 32'h1000_0004);
    check("ld_c1_stall", 32'(cpu_stall), 32'd1);
    step(); #1;
    check("ld_c2_req", 32'(req), 32'd0);
    check("ld_c2_stall", 32'(cpu_stall), 32'd1);
    step(); #1;
    check("ld_c3_stall", 32'(cpu_stall), 32'd0);
    check("ld_c3_rdata", cpu_rdata, 32'hDEAD_BEEF);
    cpu_en = 1'b0;
    step();
    check("ld_hs_count", 32'(hs_count), 32'd1);

    // Stores across the wen table
    store_and_check(4'b0100, 32'h0000_0020, 32'h00AB_0000, 2'd0, 32'h0000_0022);
    check("st_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);
    store_and_check(4'b1100, 32'h0000_0041, 32'hBEEF_0000, 2'd1, 32'h0000_0042);
    store_and_check(4'b0011, 32'h0000_0043, 32'h0000_1234, 2'd1, 32'h0000_0040);
    store_and_check(4'b1000, 32'h0000_0050, 32'h7700_0000, 2'd0, 32'h0000_0053);
    store_and_check(4'b0101, 32'h0000_0047, 32'h0011_0022, 2'd2, 32'h0000_0044);
    store_and_check(4'b1111, 32'h0000_0061, 32'hA5A5_5A5A, 2'd2, 32'h0000_0060);
    check("st_rdata_kept2", cpu_rdata, 32'hDEAD_BEEF);

    // Slow bus: addr_ok 5 cycles late, data_ok 7 cycles after that
    hs0 = hs_count;
    aok_delay = 5; dok_delay = 7; bus_rdata = 32'h1234_5678;
    start(4'd0, 32'h3000_0008, 32'h0);
    wait_done(40, lat);
    check("slow_latency", 32'(lat), 32'd15);
    check("slow_rdata", cpu_rdata, 32'h1234_5678);
    cpu_en = 1'b0;
    step();
    check("slow_hs", 32'(hs_count - hs0), 32'd1);

    // Cancel in WAIT, data_ok 3 cycles later, a new access pending behind it
    hs0 = hs_count;
    aok_delay = 0; dok_delay = 3; bus_rdata = 32'hCAFE_F00D;
    start(4'd0, 32'h4000_0000, 32'h0);
    step();
    step();
    cpu_cancel = 1'b1;
    #1;
    check("cw_stall_cancel", 32'(cpu_stall), 32'd0);
    step();
    cpu_cancel = 1'b0;
    cpu_addr = 32'h4000_0010;
    dok_delay = 0;
    #1;
    check("cw_c3_stall", 32'(cpu_stall), 32'd0);
    check("cw_c3_req", 32'(req), 32'd0);
    step(); #1;
    check("cw_c4_req", 32'(req), 32'd0);
    step(); #1;
    check("cw_c5_dok", 32'(data_ok), 32'd1);
    check("cw_c5_stall", 32'(cpu_stall), 32'd0);
    step(); #1;
    bus_rdata = 32'h55AA_55AA;
    check("cw_c6_req", 32'(req), 32'd0);
    check("cw_c6_stall", 32'(cpu_stall), 32'd1);
    check("cw_c6_rdata", cpu_rdata, 32'h1234_5678);
    step(); #1;
    check("cw_c7_req", 32'(req), 32'd1);
    check("cw_c7_addr", addr, 32'h4000_0010);
    wait_done(20, lat);
    check("cw_new_rdata", cpu_rdata, 32'h55AA_55AA);
    cpu_en = 1'b0;
    step();
    check("cw_hs", 32'(hs_count - hs0), 32'd2);

    // Cancel in REQ before addr_ok: nothing issued
    hs0 = hs_count;
    aok_delay = 3;
    start(4'd0, 32'h4400_0000, 32'h0);
    step(); step();
    cpu_cancel = 1'b1;
    #1;
    check("cr_stall", 32'(cpu_stall), 32'd0);
    step();
    cpu_cancel = 1'b0;
    cpu_en = 1'b0;
    #1;
    check("cr_req_dropped", 32'(req), 32'd0);
    step();
    check("cr_hs", 32'(hs_count - hs0), 32'd0);

    // Cancel while idle blocks the launch
    start(4'd0, 32'h4800_0000, 32'h0);
    cpu_cancel = 1'b1;
    #1;
    check("ci_stall", 32'(cpu_stall), 32'd0);
    step();
    cpu_cancel = 1'b0;
    cpu_en = 1'b0;
    #1;
    check("ci_req", 32'(req), 32'd0);
    step();

    // Back-to-back loads, en held across DONE
    hs0 = hs_count;
    aok_delay = 0; dok_delay = 0; bus_rdata = 32'h1111_2222;
    start(4'd0, 32'h5000_0000, 32'h0);
    wait_done(20, lat);
    check("b2b_first_lat", 32'(lat), 32'd3);
    check("b2b_first_rdata", cpu_rdata, 32'h1111_2222);
    bus_rdata = 32'h3333_4444;
    start(4'd0, 32'h5000_0007, 32'h0);
    wait_done(20, lat2);
    check("b2b_second_lat", 32'(lat2), 32'd4);
    check("b2b_second_rdata", cpu_rdata, 32'h3333_4444);
    cpu_en = 1'b0;
    step();
    check("b2b_hs", 32'(hs_count - hs0), 32'd2);
    check("b2b_addr_a", hs_addr[hs_addr.size()-2], 32'h5000_0000);
    check("b2b_addr_b", hs_addr[hs_addr.size()-1], 32'h5000_0004);

    // Store then load with the store's data_ok 4 cycles late
    aok_delay = 0; dok_delay = 4; bus_rdata = 32'h7777_8888;
    start(4'b1111, 32'h6000_0000, 32'hFEED_FACE);
    wait_done(30, lat);
    dok_delay = 0;
    start(4'd0, 32'h6000_0010, 32'h0);
    wait_done(30, lat2);
`ifdef DSRAM_BRIDGE_POSTED_WRITE_EN
    check("pw_store_lat", 32'(lat), 32'd2);
    check("pw_load_lat", 32'(lat2), 32'd8);
`else
    check("sw_store_lat", 32'(lat), 32'd7);
    check("sw_load_lat", 32'(lat2), 32'd4);
`endif
    check("sw_load_rdata", cpu_rdata, 32'h7777_8888);
    cpu_en = 1'b0;
    step();

    // Reset in the middle of a request
    hs0 = hs_count;
    aok_delay = 10;
    start(4'd0, 32'h7000_0000, 32'h0);
    step(); step();
    resetn = 1'b0;
    step();
    cpu_en = 1'b0;
    #1;
    check("mr_req", 32'(req), 32'd0);
    check("mr_addr", addr, 32'd0);
    check("mr_rdata", cpu_rdata, 32'd0);
    check("mr_stall", 32'(cpu_stall), 32'd0);
    resetn = 1'b1;
    step();
    check("mr_hs", 32'(hs_count - hs0), 32'd0);

    // Normal operation after reset
    aok_delay = 0; bus_rdata = 32'h9999_AAAA;
    start(4'd0, 32'h7000_0000, 32'h0);
    wait_done(20, lat);
    check("post_rst_lat", 32'(lat), 32'd3);
    check("post_rst_rdata", cpu_rdata, 32'h9999_AAAA);
    cpu_en = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
